// File: rtl/instr_reg_scheduler_pkg.sv
// Shared types for the instruction register and its front-end scheduler.
// Holds opcode/operand/address/instruction types plus the scheduler's read-FSM and requester types.
package instr_register_pkg;

   localparam int SCHED_DEPTH = 32;

   typedef enum logic [2:0] {
      ZERO  = 3'd0,
      PASSA = 3'd1,
      PASSB = 3'd2,
      ADD   = 3'd3,
      SUB   = 3'd4,
      MULT  = 3'd5,
      DIV   = 3'd6,
      MOD   = 3'd7
   } opcode_t;

   typedef logic signed [31:0] operand_t;

   typedef logic [$clog2(SCHED_DEPTH)-1:0] address_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
   } instruction_t;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_FETCH = 2'd1,
      RD_DONE  = 2'd2
   } rd_state_t;

   typedef logic req_id_t;

   // Queue pointers are modulo the register depth; the address width makes the wrap implicit.
   function automatic address_t ptr_inc(input address_t p);
      return p + address_t'(1);
   endfunction

endpackage

// File: rtl/instr_reg_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter: the priority holder wins a tie, and priority
// passes to the other requester after every accepted grant.
module rr_arbiter2
   import instr_register_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_valid,
   input  logic       i_accept,
   output logic [1:0] o_grant,
   output req_id_t    o_priority
);

   req_id_t r_prio;

   always_comb begin
      o_grant    = 2'b00;
      o_grant[0] = i_valid[0] & (~i_valid[1] | (r_prio == 1'b0));
      o_grant[1] = i_valid[1] & (~i_valid[0] | (r_prio == 1'b1));
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_prio <= 1'b0;
      end else if (i_accept) begin
         r_prio <= o_grant[0];
      end
   end

   assign o_priority = r_prio;

endmodule

// File: rtl/instr_reg_scheduler.sv
// Front-end controller for the 32-entry instruction register: arbitrated circular-queue writes
// and oldest-first reads through a three-state read FSM. Optional statistics: INSTR_SCHED_STATS_EN.
module instr_reg_scheduler
   import instr_register_pkg::*;
#(
   parameter int DEPTH = SCHED_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  instruction_t req0_instr,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  instruction_t req1_instr,
   output logic         load_en,
   output address_t     write_pointer,
   output opcode_t      opcode,
   output operand_t     operand_a,
   output operand_t     operand_b,
   output address_t     read_pointer,
   input  instruction_t instruction_word,
   input  logic         rd_req,
   output logic         rd_valid,
   output instruction_t rd_instr,
   output logic [AW:0]  count,
   output logic         full,
   output logic         empty
`ifdef INSTR_SCHED_STATS_EN
   ,
   output logic [31:0]  grant0_cnt,
   output logic [31:0]  grant1_cnt,
   output logic [31:0]  stall_cnt
`endif
);

   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [1:0]   w_grant;
   req_id_t      w_unused_prio;
   logic         w_accept;
   instruction_t w_wr_instr;
   logic         w_rd_grant;
   logic         w_rd_capture;
   rd_state_t    w_state_next;

   address_t     r_wr_ptr;
   address_t     r_rd_ptr;
   logic [AW:0]  r_count;
   rd_state_t    r_state;

   assign count      = r_count;
   assign full       = (r_count == CNT_FULL);
   assign empty      = (r_count == '0);
   assign req0_ready = w_grant[0] & ~full;
   assign req1_ready = w_grant[1] & ~full;
   assign w_accept   = (|w_grant) & ~full;
   assign w_wr_instr = w_grant[1] ? req1_instr : req0_instr;

   rr_arbiter2 u_arb (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_valid    ({req1_valid, req0_valid}),
      .i_accept   (w_accept),
      .o_grant    (w_grant),
      .o_priority (w_unused_prio)
   );

   // Write stage: the register captures these outputs one edge after the accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_en       <= 1'b0;
         write_pointer <= '0;
         opcode        <= ZERO;
         operand_a     <= '0;
         operand_b     <= '0;
         r_wr_ptr      <= '0;
      end else begin
         load_en <= w_accept;
         if (w_accept) begin
            write_pointer <= r_wr_ptr;
            opcode        <= w_wr_instr.opc;
            operand_a     <= w_wr_instr.op_a;
            operand_b     <= w_wr_instr.op_b;
            r_wr_ptr      <= ptr_inc(r_wr_ptr);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         case ({w_accept, w_rd_grant})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RD_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_rd_grant   = 1'b0;
      w_rd_capture = 1'b0;
      case (r_state)
         RD_IDLE: begin
            if (rd_req && !empty) begin
               w_rd_grant   = 1'b1;
               w_state_next = RD_FETCH;
            end
         end
         RD_FETCH: begin
            w_rd_capture = 1'b1;
            w_state_next = RD_DONE;
         end
         RD_DONE: begin
            w_state_next = RD_IDLE;
         end
         default: begin
            w_state_next = RD_IDLE;
         end
      endcase
   end

   // Read stage: address goes out on the grant edge, data is sampled on the following edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_pointer <= '0;
         r_rd_ptr     <= '0;
         rd_valid     <= 1'b0;
         rd_instr     <= '0;
      end else begin
         rd_valid <= w_rd_capture;
         if (w_rd_grant) begin
            read_pointer <= r_rd_ptr;
            r_rd_ptr     <= ptr_inc(r_rd_ptr);
         end
         if (w_rd_capture) begin
            rd_instr <= instruction_word;
         end
      end
   end

`ifdef INSTR_SCHED_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic w_stall;
   assign w_stall = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant0_cnt <= '0;
         grant1_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (req0_valid && req0_ready) grant0_cnt <= sat_inc(grant0_cnt);
         if (req1_valid && req1_ready) grant1_cnt <= sat_inc(grant1_cnt);
         if (w_stall)                  stall_cnt  <= sat_inc(stall_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed bench for instr_reg_scheduler; models the attached instruction register as a simple array.
// Statistics checks are compiled in when INSTR_SCHED_STATS_EN is defined.
module tb_instr_reg_scheduler;
   import instr_register_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   instruction_t req0_instr, req1_instr;
   logic         load_en;
   address_t     write_pointer, read_pointer;
   opcode_t      opcode;
   operand_t     operand_a, operand_b;
   instruction_t instruction_word;
   logic         rd_req, rd_valid;
   instruction_t rd_instr;
   logic [5:0]   count;
   logic         full, empty;
`ifdef INSTR_SCHED_STATS_EN
   logic [31:0]  grant0_cnt, grant1_cnt, stall_cnt;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;

   instruction_t mem [32];

   always #5 clk = ~clk;

   instr_reg_scheduler dut (
      .clk              (clk),
      .reset            (reset),
      .req0_valid       (req0_valid),
      .req0_ready       (req0_ready),
      .req0_instr       (req0_instr),
      .req1_valid       (req1_valid),
      .req1_ready       (req1_ready),
      .req1_instr       (req1_instr),
      .load_en          (load_en),
      .write_pointer    (write_pointer),
      .opcode           (opcode),
      .operand_a        (operand_a),
      .operand_b        (operand_b),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .rd_req           (rd_req),
      .rd_valid         (rd_valid),
      .rd_instr         (rd_instr),
      .count            (count),
      .full             (full),
      .empty            (empty)
`ifdef INSTR_SCHED_STATS_EN
      ,
      .grant0_cnt       (grant0_cnt),
      .grant1_cnt       (grant1_cnt),
      .stall_cnt        (stall_cnt)
`endif
   );

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
   end

   always @(posedge clk) begin
      if (load_en) mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b};
   end

   assign instruction_word = mem[read_pointer];

   function automatic instruction_t mk(input opcode_t o, input int a, input int b);
      return '{opc: o, op_a: a, op_b: b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_instr = '0;
      req1_instr = '0;
      rd_req     = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #3;
      chk_cnt++; if (load_en !== 1'b0) $display("FAIL rst_load_en got %0b want 0", load_en); else pass_cnt++;
      chk_cnt++; if (count !== 6'd0) $display("FAIL rst_count got %0d want 0", count); else pass_cnt++;
      chk_cnt++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_flags got empty=%0b full=%0b want 1/0", empty, full); else pass_cnt++;
      chk_cnt++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %0b want 0", rd_valid); else pass_cnt++;
      tick();
      reset = 1'b0;
      req0_valid = 1'b1;
      req0_instr = mk(ADD, 1, 2);
      tick();
      req0_instr = mk(SUB, 3, 4);
      rd_req = 1'b1;
      tick();
      chk_cnt++; if (load_en !== 1'b1 || write_pointer !== 5'd1) $display("FAIL rst_preburst got load_en=%0b wp=%0d want 1/1", load_en, write_pointer); else pass_cnt++;
      chk_cnt++; if (count !== 6'd1) $display("FAIL rst_precount got %0d want 1", count); else pass_cnt++;
      reset = 1'b1;
      #1;
      chk_cnt++; if (load_en !== 1'b0 || write_pointer !== 5'd0) $display("FAIL rst_async_wr got load_en=%0b wp=%0d want 0/0", load_en, write_pointer); else pass_cnt++;
      chk_cnt++; if (opcode !== ZERO || operand_a !== 32'sd0 || operand_b !== 32'sd0) $display("FAIL rst_async_data got %0d/%0d/%0d want 0/0/0", opcode, operand_a, operand_b); else pass_cnt++;
      chk_cnt++; if (count !== 6'd0 || empty !== 1'b1) $display("FAIL rst_async_count got count=%0d empty=%0b want 0/1", count, empty); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_suppressed got %0b want 0", rd_valid); else pass_cnt++;
      idle_inputs();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_writer();
      instruction_t vec [3];
      vec[0] = mk(ADD, 5, 3);
      vec[1] = mk(SUB, -7, 2);
      vec[2] = mk(MULT, 4, 4);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req0_valid = 1'b1;
         req0_instr = vec[i];
         #1;
         chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL sw_ready%0d got %0b want 1", i, req0_ready); else pass_cnt++;
         @(posedge clk); #1;
         chk_cnt++; if (load_en !== 1'b1 || write_pointer !== 5'(i)) $display("FAIL sw_wr%0d got load_en=%0b wp=%0d want 1/%0d", i, load_en, write_pointer, i); else pass_cnt++;
         chk_cnt++; if (opcode !== vec[i].opc || operand_a !== vec[i].op_a || operand_b !== vec[i].op_b)
            $display("FAIL sw_data%0d got %0d/%0d/%0d want %0d/%0d/%0d", i, opcode, operand_a, operand_b, vec[i].opc, vec[i].op_a, vec[i].op_b);
         else pass_cnt++;
      end
      req0_valid = 1'b0;
      tick();
      chk_cnt++; if (load_en !== 1'b0 || write_pointer !== 5'd2 || opcode !== MULT) $display("FAIL sw_hold got load_en=%0b wp=%0d opc=%0d want 0/2/MULT", load_en, write_pointer, opcode); else pass_cnt++;
      chk_cnt++; if (count !== 6'd3) $display("FAIL sw_count got %0d want 3", count); else pass_cnt++;
   endtask

   task automatic test_contention();
      do_reset();
      req0_valid = 1'b1;
      req0_instr = mk(ADD, 1, 1);
      req1_valid = 1'b1;
      req1_instr = mk(SUB, 2, 2);
      for (int i = 0; i < 4; i++) begin
         logic    g;
         opcode_t want_opc;
         g = (i % 2 == 1);
         want_opc = g ? SUB : ADD;
         #1;
         chk_cnt++; if (req0_ready !== ~g || req1_ready !== g) $display("FAIL ct_ready%0d got r0=%0b r1=%0b want %0b/%0b", i, req0_ready, req1_ready, ~g, g); else pass_cnt++;
         @(posedge clk); #1;
         chk_cnt++; if (write_pointer !== 5'(i) || opcode !== want_opc) $display("FAIL ct_wr%0d got wp=%0d opc=%0d want %0d/%0d", i, write_pointer, opcode, i, want_opc); else pass_cnt++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk_cnt++; if (count !== 6'd4) $display("FAIL ct_count got %0d want 4", count); else pass_cnt++;
`ifdef INSTR_SCHED_STATS_EN
      chk_cnt++; if (grant0_cnt !== 32'd2 || grant1_cnt !== 32'd2 || stall_cnt !== 32'd4)
         $display("FAIL ct_stats got g0=%0d g1=%0d st=%0d want 2/2/4", grant0_cnt, grant1_cnt, stall_cnt);
      else pass_cnt++;
`endif
      tick();
   endtask

   task automatic test_full_wrap();
      int n_reads;
      instruction_t want;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         req0_valid = 1'b1;
         req0_instr = mk(ADD, i, i + 100);
         tick();
      end
      chk_cnt++; if (count !== 6'd32 || full !== 1'b1) $display("FAIL fw_full got count=%0d full=%0b want 32/1", count, full); else pass_cnt++;
      req0_instr = mk(MOD, 100, 0);
      #1;
      chk_cnt++; if (req0_ready !== 1'b0) $display("FAIL fw_ready_full got %0b want 0", req0_ready); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (load_en !== 1'b0 || count !== 6'd32) $display("FAIL fw_blocked got load_en=%0b count=%0d want 0/32", load_en, count); else pass_cnt++;
      rd_req = 1'b1;
      tick();
      chk_cnt++; if (count !== 6'd31 || read_pointer !== 5'd0 || full !== 1'b0) $display("FAIL fw_rd_grant got count=%0d rp=%0d full=%0b want 31/0/0", count, read_pointer, full); else pass_cnt++;
      rd_req = 1'b0;
      #1;
      chk_cnt++; if (req0_ready !== 1'b1) $display("FAIL fw_ready_freed got %0b want 1", req0_ready); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (rd_valid !== 1'b1 || rd_instr !== mk(ADD, 0, 100)) $display("FAIL fw_rd_entry0 got vld=%0b instr=%h want 1/%h", rd_valid, rd_instr, mk(ADD, 0, 100)); else pass_cnt++;
      chk_cnt++; if (load_en !== 1'b1 || write_pointer !== 5'd0 || full !== 1'b1) $display("FAIL fw_wr_wrap got load_en=%0b wp=%0d full=%0b want 1/0/1", load_en, write_pointer, full); else pass_cnt++;
      req0_valid = 1'b0;
      rd_req = 1'b1;
      n_reads = 0;
      for (int cyc = 0; cyc < 300 && n_reads < 32; cyc++) begin
         tick();
         if (rd_valid === 1'b1) begin
            want = (n_reads < 31) ? mk(ADD, n_reads + 1, n_reads + 101) : mk(MOD, 100, 0);
            chk_cnt++; if (rd_instr !== want) $display("FAIL fw_drain%0d got %h want %h", n_reads, rd_instr, want); else pass_cnt++;
            n_reads++;
         end
      end
      rd_req = 1'b0;
      chk_cnt++; if (n_reads !== 32) $display("FAIL fw_drain_count got %0d want 32", n_reads); else pass_cnt++;
      chk_cnt++; if (read_pointer !== 5'd0 || empty !== 1'b1) $display("FAIL fw_rd_wrap got rp=%0d empty=%0b want 0/1", read_pointer, empty); else pass_cnt++;
      tick();
   endtask

   task automatic test_readback();
      int seen;
      do_reset();
      rd_req = 1'b1;
      seen = 0;
      repeat (5) begin
         tick();
         if (rd_valid === 1'b1) seen++;
      end
      chk_cnt++; if (seen !== 0) $display("FAIL rb_empty_pulses got %0d want 0", seen); else pass_cnt++;
      chk_cnt++; if (read_pointer !== 5'd0 || empty !== 1'b1) $display("FAIL rb_empty_state got rp=%0d empty=%0b want 0/1", read_pointer, empty); else pass_cnt++;
      req1_valid = 1'b1;
      req1_instr = mk(DIV, 9, -3);
      #1;
      chk_cnt++; if (req1_ready !== 1'b1) $display("FAIL rb_ready1 got %0b want 1", req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      chk_cnt++; if (count !== 6'd1 || write_pointer !== 5'd0) $display("FAIL rb_write got count=%0d wp=%0d want 1/0", count, write_pointer); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 1'b0 || count !== 6'd0) $display("FAIL rb_grant got vld=%0b count=%0d want 0/0", rd_valid, count); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 1'b1 || rd_instr !== mk(DIV, 9, -3)) $display("FAIL rb_data got vld=%0b instr=%h want 1/%h", rd_valid, rd_instr, mk(DIV, 9, -3)); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 1'b0) $display("FAIL rb_pulse got %0b want 0", rd_valid); else pass_cnt++;
      rd_req = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req0_valid = 1'b1;
         req0_instr = mk(ADD, 10 + i, i);
         tick();
      end
      chk_cnt++; if (count !== 6'd5) $display("FAIL sim_pre_count got %0d want 5", count); else pass_cnt++;
      req0_instr = mk(PASSA, 7, 7);
      req1_valid = 1'b1;
      req1_instr = mk(SUB, 50, 5);
      rd_req = 1'b1;
      #1;
      chk_cnt++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL sim_prio got r0=%0b r1=%0b want 0/1", req0_ready, req1_ready); else pass_cnt++;
      @(posedge clk); #1;
      idle_inputs();
      chk_cnt++; if (count !== 6'd5) $display("FAIL sim_count got %0d want 5", count); else pass_cnt++;
      chk_cnt++; if (load_en !== 1'b1 || write_pointer !== 5'd5 || opcode !== SUB) $display("FAIL sim_wr got load_en=%0b wp=%0d opc=%0d want 1/5/SUB", load_en, write_pointer, opcode); else pass_cnt++;
      chk_cnt++; if (read_pointer !== 5'd0) $display("FAIL sim_rp got %0d want 0", read_pointer); else pass_cnt++;
      tick();
      chk_cnt++; if (rd_valid !== 1'b1 || rd_instr !== mk(ADD, 10, 0)) $display("FAIL sim_rd got vld=%0b instr=%h want 1/%h", rd_valid, rd_instr, mk(ADD, 10, 0)); else pass_cnt++;
`ifdef INSTR_SCHED_STATS_EN
      chk_cnt++; if (grant0_cnt !== 32'd5 || grant1_cnt !== 32'd1 || stall_cnt !== 32'd1)
         $display("FAIL sim_stats got g0=%0d g1=%0d st=%0d want 5/1/1", grant0_cnt, grant1_cnt, stall_cnt);
      else pass_cnt++;
`endif
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_writer();
      test_contention();
      test_full_wrap();
      test_readback();
      test_simultaneous();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
